// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants for the MIPS control units (single-cycle and multicycle):
//   - opcode values of the supported instruction subset
//   - alu_op codes driven towards the ALU control
//   - multicycle controller state encodings
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // alu_op codes
  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SLTU  = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_XOR   = 3'b111;

  // Multicycle controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// ---------------------------------------------------------------------------
// opcode_class
// Combinational classification of an opcode into the instruction families the
// multicycle controller branches on in DECODE.
//   i_opcode    in  6  IR[31:26]
//   o_is_mem    out 1  lw or sw
//   o_is_rtype  out 1  R-type (opcode 000000)
//   o_is_imm    out 1  addi/slti/sltiu/andi/ori/xori/lui
//   o_is_branch out 1  beq or bne
//   o_is_j      out 1  j
//   o_is_jal    out 1  jal
//   o_legal     out 1  opcode belongs to the supported subset
// ---------------------------------------------------------------------------
module opcode_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic       o_is_mem,
  output logic       o_is_rtype,
  output logic       o_is_imm,
  output logic       o_is_branch,
  output logic       o_is_j,
  output logic       o_is_jal,
  output logic       o_legal
);

  always_comb begin
    o_is_mem    = 1'b0;
    o_is_rtype  = 1'b0;
    o_is_imm    = 1'b0;
    o_is_branch = 1'b0;
    o_is_j      = 1'b0;
    o_is_jal    = 1'b0;
    case (i_opcode)
      OP_LW, OP_SW:       o_is_mem    = 1'b1;
      OP_RTYPE:           o_is_rtype  = 1'b1;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:
                          o_is_imm    = 1'b1;
      OP_BEQ, OP_BNE:     o_is_branch = 1'b1;
      OP_J:               o_is_j      = 1'b1;
      OP_JAL:             o_is_jal    = 1'b1;
      default:            ;
    endcase
    o_legal = o_is_mem | o_is_rtype | o_is_imm | o_is_branch | o_is_j | o_is_jal;
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing a multicycle MIPS datapath (one memory port, one ALU).
//   clk, reset (async, active-low)
//   opcode, mem_ready                 inputs
//   pc_write, pc_write_cond, branch_ne, pc_source  PC update controls
//   i_or_d, mem_read, mem_write, ir_write          memory / IR controls
//   reg_dst, mem_to_reg, reg_write                 register file controls
//   alu_src_a, alu_src_b, alu_op, sign_or_zero     ALU controls
//   illegal_op                        pulse in DECODE for unsupported opcode
//   state                             current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               sign_or_zero,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t r_state;
  state_t w_nextState;

  logic w_isMem, w_isRtype, w_isImm, w_isBranch, w_isJ, w_isJal, w_legal;

  opcode_class u_opcodeClass (
    .i_opcode   (opcode),
    .o_is_mem   (w_isMem),
    .o_is_rtype (w_isRtype),
    .o_is_imm   (w_isImm),
    .o_is_branch(w_isBranch),
    .o_is_j     (w_isJ),
    .o_is_jal   (w_isJal),
    .o_legal    (w_legal)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_nextState;
  end

  assign state = STATE_W'(r_state);

  // Next-state and per-state outputs. FETCH is the only state whose strobes
  // follow mem_ready combinationally, so the IR/PC load lands on the cycle the
  // memory completes.
  always_comb begin
    w_nextState   = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    sign_or_zero  = 1'b1;
    illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_nextState = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        if      (w_isMem)    w_nextState = S_MEM_ADDR;
        else if (w_isRtype)  w_nextState = S_R_EXEC;
        else if (w_isImm)    w_nextState = S_I_EXEC;
        else if (w_isBranch) w_nextState = S_BRANCH;
        else if (w_isJ)      w_nextState = S_JUMP;
        else if (w_isJal)    w_nextState = S_JAL;
        else                 w_nextState = S_FETCH;
        illegal_op = ~w_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_op      = ALU_ADD;
        w_nextState = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_nextState = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = 2'b01;
        w_nextState = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_nextState = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_op      = ALU_FUNCT;
        w_nextState = S_R_WB;
      end
      S_R_WB: begin
        reg_write   = 1'b1;
        reg_dst     = 2'b01;
        w_nextState = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: begin alu_op = ALU_SLTU; sign_or_zero = 1'b0; end
          OP_ANDI:  begin alu_op = ALU_AND;  sign_or_zero = 1'b0; end
          OP_ORI:   begin alu_op = ALU_OR;   sign_or_zero = 1'b0; end
          OP_XORI:  begin alu_op = ALU_XOR;  sign_or_zero = 1'b0; end
          OP_LUI:   begin alu_op = ALU_ADD;  sign_or_zero = 1'b0; end
          default:  alu_op = ALU_ADD;
        endcase
        w_nextState = S_I_WB;
      end
      S_I_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = (opcode == OP_LUI) ? 2'b11 : 2'b00;
        w_nextState = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        w_nextState   = S_FETCH;
      end
      S_JUMP: begin
        pc_write    = 1'b1;
        pc_source   = 2'b10;
        w_nextState = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4, which is the link value written to $31.
        pc_write    = 1'b1;
        pc_source   = 2'b10;
        reg_write   = 1'b1;
        reg_dst     = 2'b10;
        mem_to_reg  = 2'b10;
        w_nextState = S_FETCH;
      end
      default: w_nextState = S_FETCH;
    endcase

    // While reset is held no strobe may fire, even though the state reads
    // FETCH and mem_ready may be high.
    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d;
  logic       mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, sign_or_zero, illegal_op;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int compareCount  = 0;
  int mismatchCount = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne    (branch_ne),
    .pc_source    (pc_source),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .sign_or_zero (sign_or_zero),
    .illegal_op   (illegal_op),
    .state        (state)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge and drive this cycle's inputs, then
  // wait for outputs to settle before any checks.
  task automatic applyStimulus(input logic [5:0] op, input logic ready);
    @(negedge clk);
    opcode    = op;
    mem_ready = ready;
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 6'b100011;
    mem_ready = 1'b1;

    // Reset state: FETCH, strobes quiet even with mem_ready high
    #1;
    checkOutput("rst_state",    32'(state),    32'd0);
    checkOutput("rst_ir_write", 32'(ir_write), 32'd0);
    checkOutput("rst_pc_write", 32'(pc_write), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_alu_src_b", 32'(alu_src_b), 32'd1);
    @(negedge clk);
    @(negedge clk);

    // ---- lw, mem_ready=1: states 0,1,2,3,4,0 ----
    reset = 1'b1;
    #1;
    checkOutput("lw_c1_state",  32'(state),    32'd0);
    checkOutput("lw_c1_irw",    32'(ir_write), 32'd1);
    checkOutput("lw_c1_pcw",    32'(pc_write), 32'd1);
    checkOutput("lw_c1_rw",     32'(reg_write), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_c2_state",  32'(state),    32'd1);
    checkOutput("lw_c2_srcb",   32'(alu_src_b), 32'd3);
    checkOutput("lw_c2_rw",     32'(reg_write), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_c3_state",  32'(state),    32'd2);
    checkOutput("lw_c3_srcb",   32'(alu_src_b), 32'd2);
    checkOutput("lw_c3_srca",   32'(alu_src_a), 32'd1);
    checkOutput("lw_c3_rw",     32'(reg_write), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_c4_state",  32'(state),    32'd3);
    checkOutput("lw_c4_mrd",    32'(mem_read), 32'd1);
    checkOutput("lw_c4_iord",   32'(i_or_d),   32'd1);
    checkOutput("lw_c4_rw",     32'(reg_write), 32'd0);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_c5_state",  32'(state),      32'd4);
    checkOutput("lw_c5_rw",     32'(reg_write),  32'd1);
    checkOutput("lw_c5_m2r",    32'(mem_to_reg), 32'd1);

    // ---- FETCH wait: 3 cycles mem_ready=0, then 1 ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b000101, 1'b0);
      checkOutput($sformatf("fw%0d_state", i), 32'(state),    32'd0);
      checkOutput($sformatf("fw%0d_mrd", i),   32'(mem_read), 32'd1);
      checkOutput($sformatf("fw%0d_irw", i),   32'(ir_write), 32'd0);
      checkOutput($sformatf("fw%0d_pcw", i),   32'(pc_write), 32'd0);
    end
    applyStimulus(6'b000101, 1'b1);
    checkOutput("fw3_mrd", 32'(mem_read), 32'd1);
    checkOutput("fw3_irw", 32'(ir_write), 32'd1);
    checkOutput("fw3_pcw", 32'(pc_write), 32'd1);

    // ---- bne ----
    applyStimulus(6'b000101, 1'b0);
    checkOutput("bne_dec_state", 32'(state), 32'd1);
    applyStimulus(6'b000101, 1'b0);
    checkOutput("bne_state", 32'(state),         32'd10);
    checkOutput("bne_pwc",   32'(pc_write_cond), 32'd1);
    checkOutput("bne_bne",   32'(branch_ne),     32'd1);
    checkOutput("bne_psrc",  32'(pc_source),     32'd1);
    checkOutput("bne_aluop", 32'(alu_op),        32'd1);
    checkOutput("bne_pcw",   32'(pc_write),      32'd0);

    // ---- beq ----
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beq_fetch_state", 32'(state), 32'd0);
    applyStimulus(6'b000100, 1'b1);
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beq_state", 32'(state),     32'd10);
    checkOutput("beq_bne",   32'(branch_ne), 32'd0);

    // ---- jal ----
    applyStimulus(6'b000011, 1'b1);
    applyStimulus(6'b000011, 1'b1);
    applyStimulus(6'b000011, 1'b1);
    checkOutput("jal_state", 32'(state),      32'd12);
    checkOutput("jal_pcw",   32'(pc_write),   32'd1);
    checkOutput("jal_psrc",  32'(pc_source),  32'd2);
    checkOutput("jal_rw",    32'(reg_write),  32'd1);
    checkOutput("jal_rdst",  32'(reg_dst),    32'd2);
    checkOutput("jal_m2r",   32'(mem_to_reg), 32'd2);
    applyStimulus(6'b001100, 1'b1);
    checkOutput("jal_next_state", 32'(state), 32'd0);

    // ---- andi ----
    applyStimulus(6'b001100, 1'b1);
    applyStimulus(6'b001100, 1'b1);
    checkOutput("andi_ex_state", 32'(state),        32'd8);
    checkOutput("andi_aluop",    32'(alu_op),       32'd5);
    checkOutput("andi_soz",      32'(sign_or_zero), 32'd0);
    applyStimulus(6'b001100, 1'b1);
    checkOutput("andi_wb_state", 32'(state),      32'd9);
    checkOutput("andi_wb_rw",    32'(reg_write),  32'd1);
    checkOutput("andi_wb_m2r",   32'(mem_to_reg), 32'd0);
    checkOutput("andi_wb_rdst",  32'(reg_dst),    32'd0);

    // ---- lui ----
    applyStimulus(6'b001111, 1'b1);
    applyStimulus(6'b001111, 1'b1);
    applyStimulus(6'b001111, 1'b1);
    checkOutput("lui_aluop", 32'(alu_op),       32'd3);
    checkOutput("lui_soz",   32'(sign_or_zero), 32'd0);
    applyStimulus(6'b001111, 1'b1);
    checkOutput("lui_wb_m2r", 32'(mem_to_reg), 32'd3);

    // ---- slti keeps sign extension ----
    applyStimulus(6'b001010, 1'b1);
    applyStimulus(6'b001010, 1'b1);
    applyStimulus(6'b001010, 1'b1);
    checkOutput("slti_aluop", 32'(alu_op),       32'd2);
    checkOutput("slti_soz",   32'(sign_or_zero), 32'd1);
    applyStimulus(6'b001010, 1'b1);

    // ---- R-type ----
    applyStimulus(6'b000000, 1'b1);
    applyStimulus(6'b000000, 1'b1);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_ex_state", 32'(state),  32'd6);
    checkOutput("r_ex_aluop", 32'(alu_op), 32'd0);
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_wb_state", 32'(state),     32'd7);
    checkOutput("r_wb_rdst",  32'(reg_dst),   32'd1);
    checkOutput("r_wb_rw",    32'(reg_write), 32'd1);

    // ---- illegal opcode ----
    applyStimulus(6'b111111, 1'b1);
    applyStimulus(6'b111111, 1'b1);
    checkOutput("ill_state", 32'(state),      32'd1);
    checkOutput("ill_pulse", 32'(illegal_op), 32'd1);
    checkOutput("ill_rw",    32'(reg_write),  32'd0);
    checkOutput("ill_mw",    32'(mem_write),  32'd0);
    applyStimulus(6'b101011, 1'b1);
    checkOutput("ill_next_state", 32'(state),      32'd0);
    checkOutput("ill_next_pulse", 32'(illegal_op), 32'd0);

    // ---- sw with one wait cycle in MEM_WRITE ----
    applyStimulus(6'b101011, 1'b1);
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_addr_state", 32'(state), 32'd2);
    applyStimulus(6'b101011, 1'b0);
    checkOutput("sw_wait_state", 32'(state),     32'd5);
    checkOutput("sw_wait_mw",    32'(mem_write), 32'd1);
    checkOutput("sw_wait_iord",  32'(i_or_d),    32'd1);
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_done_state", 32'(state),     32'd5);
    applyStimulus(6'b100011, 1'b1);
    checkOutput("sw_next_state", 32'(state), 32'd0);

    // ---- reset during MEM_READ wait ----
    applyStimulus(6'b100011, 1'b1);
    applyStimulus(6'b100011, 1'b1);
    applyStimulus(6'b100011, 1'b0);
    checkOutput("rmid_wait_state", 32'(state),     32'd3);
    checkOutput("rmid_wait_rw",    32'(reg_write), 32'd0);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("rmid_state", 32'(state),    32'd0);
    checkOutput("rmid_mrd",   32'(mem_read), 32'd0);
    checkOutput("rmid_irw",   32'(ir_write), 32'd0);
    checkOutput("rmid_rw",    32'(reg_write), 32'd0);
    @(negedge clk);
    checkOutput("rmid_hold_state", 32'(state), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rrel_irw", 32'(ir_write), 32'd1);
    applyStimulus(6'b000010, 1'b1);
    checkOutput("rrel_state", 32'(state), 32'd1);
    applyStimulus(6'b000010, 1'b1);
    checkOutput("j_state", 32'(state),     32'd11);
    checkOutput("j_psrc",  32'(pc_source), 32'd2);
    checkOutput("j_rw",    32'(reg_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM controller that sequences the MIPS datapath in multicycle mode with one shared memory port and one ALU. It replaces the per-instruction combinational decode with state-by-state strobes. It supports the same instruction subset: R-type, beq, bne, addi, slti, sltiu, andi, ori, xori, lui, lw, sw, j and jal. Every memory access waits on a ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the debug state output.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
opcode  in  6  IR[31:26]; stable from DECODE onward.
mem_ready  in  1  memory has completed the current read or write this cycle.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load when the branch condition holds.
branch_ne  out  1  1 = take the branch on ALU not-zero (bne); 0 = take it on zero (beq).
pc_source  out  2  00 ALU result; 01 ALUOut; 10 jump target.
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
ir_write  out  1  IR load.
reg_dst  out  2  destination select: 00 rt; 01 rd; 10 $31.
mem_to_reg  out  2  write-back select: 00 ALUOut; 01 MDR; 10 PC; 11 imm<<16.
reg_write  out  1  register file write enable.
alu_src_a  out  1  ALU A select: 0 PC, 1 A register.
alu_src_b  out  2  ALU B select: 00 B; 01 constant 4; 10 ext imm; 11 ext imm<<2.
alu_op  out  3  000 R-type (use funct); 001 sub; 010 slt; 011 add; 100 sltu; 101 and; 110 or; 111 xor.
sign_or_zero  out  1  1 sign-extend, 0 zero-extend.
illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
state  out  STATE_W  current state (debug).

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12. Codes 13-15 are unreachable; if entered, go to FETCH.
- Reset (reset=0, asynchronous): state=FETCH, and all strobes/enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) are forced to 0. Remaining outputs take their FETCH values. Reset has priority mid-instruction; a partially executed instruction is abandoned.
- Default value of every output not listed for a state: 0, except sign_or_zero=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=011, pc_source=00. ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=011 (precomputes the branch target).
  - lw/sw -> MEM_ADDR.
  - 000000 -> R_EXEC.
  - addi/slti/sltiu/andi/ori/xori/lui -> I_EXEC.
  - beq/bne -> BRANCH.
  - j -> JUMP.
  - jal -> JAL.
  - Any other opcode: illegal_op=1, -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=011, sign_or_zero=1. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=000; -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op per opcode: addi 011, slti 010, sltiu 100, andi 101, ori 110, xori 111, lui 011. sign_or_zero=0 for sltiu/andi/ori/xori/lui, 1 otherwise; -> I_WB.
- I_WB: reg_write=1, reg_dst=00. mem_to_reg=11 for lui, 00 otherwise; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101); -> FETCH.
- JUMP: pc_write=1, pc_source=10; -> FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4); -> FETCH.
- Latency with mem_ready always 1:
  - j, jal, beq, bne: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle of mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds exactly 1 cycle.
- mem_read/mem_write stay asserted, with constant address select, for the whole wait.
- Writes never occur in a wait cycle.
- mem_ready outside the memory states is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds three sets of constants:
  - opcode constants (OP_RTYPE, OP_BEQ, ... OP_JAL);
  - alu_op codes;
  - state encodings.
- The single-cycle control unit also imports this package.
- One sub-module, opcode_class: combinational opcode -> {is_mem, is_rtype, is_imm, is_branch, is_j, is_jal, legal}, used by the next-state logic.

Test Plan:
- lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=01 only in cycle 5.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> mem_read=1 for 4 cycles; ir_write=pc_write=1 only in the 4th; DECODE next.
- bne (000101) -> BRANCH in cycle 3 with pc_write_cond=1, branch_ne=1, pc_source=01, alu_op=001; beq gives branch_ne=0.
- jal (000011) -> cycle 3 shows pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; then FETCH.
- andi (001100) -> I_EXEC with alu_op=101, sign_or_zero=0; I_WB with reg_write=1; lui gives mem_to_reg=11 in I_WB.
- Opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no reg/mem write. Reset=0 asserted during MEM_READ wait -> state=0 immediately and all enables 0; after release, FETCH restarts cleanly.
